// File: rtl/pwm_capture.sv
// Servo-style PWM receiver: measures high time and rise-to-rise period in 1 us units,
// flags out-of-range pulses and reports loss of signal after an edge-free timeout.
module pwm_capture #(
    parameter int unsigned CLK_VAL_MHZ  = 50,
    parameter int unsigned TIMEOUT_US   = 25000,
    parameter int unsigned MIN_PULSE_US = 500,
    parameter int unsigned MAX_PULSE_US = 2500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        pwm_in,
    output logic [15:0] pulse_width,
    output logic [19:0] period,
    output logic        valid,
    output logic        out_of_range,
    output logic        signal_lost
);

    localparam int unsigned PrescW = (CLK_VAL_MHZ > 1) ? $clog2(CLK_VAL_MHZ) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_VAL_MHZ - 1);
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_US);
    localparam logic [15:0] MinVal     = 16'(MIN_PULSE_US);
    localparam logic [15:0] MaxVal     = 16'(MAX_PULSE_US);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e            r_state, w_state_nxt;
    logic              r_sync1, r_sync2, r_prev;
    logic [PrescW-1:0] r_presc, w_presc_nxt;
    logic [15:0]       r_hi_cnt, w_hi_cnt_nxt;
    logic [19:0]       r_per_cnt, w_per_cnt_nxt;
    logic [15:0]       r_idle_cnt, w_idle_cnt_nxt;
    logic [15:0]       r_pulse_width, w_pulse_width_nxt;
    logic [19:0]       r_period, w_period_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_oor, w_oor_nxt;
    logic              r_lost, w_lost_nxt;

    logic        w_rise, w_fall, w_tick, w_timeout;
    logic [15:0] w_hi_inc, w_idle_inc;
    logic [19:0] w_per_inc;

    assign w_rise     = r_sync2 & ~r_prev;
    assign w_fall     = ~r_sync2 & r_prev;
    assign w_tick     = (r_presc == PrescMax);
    assign w_timeout  = (r_idle_cnt >= TimeoutVal);
    assign w_hi_inc   = (r_hi_cnt == 16'hFFFF) ? r_hi_cnt : r_hi_cnt + 16'd1;
    assign w_per_inc  = (r_per_cnt == 20'hFFFFF) ? r_per_cnt : r_per_cnt + 20'd1;
    assign w_idle_inc = (r_idle_cnt == 16'hFFFF) ? r_idle_cnt : r_idle_cnt + 16'd1;

    always_comb begin
        w_state_nxt       = r_state;
        w_hi_cnt_nxt      = r_hi_cnt;
        w_per_cnt_nxt     = r_per_cnt;
        w_idle_cnt_nxt    = r_idle_cnt;
        w_pulse_width_nxt = r_pulse_width;
        w_period_nxt      = r_period;
        w_valid_nxt       = 1'b0;
        w_oor_nxt         = r_oor;
        w_lost_nxt        = r_lost;
        // Realigning on rise makes the measurement phase start at the rising edge.
        w_presc_nxt       = (w_rise || w_tick) ? '0 : r_presc + PrescW'(1);

        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_hi_cnt_nxt   = '0;
                    w_per_cnt_nxt  = '0;
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = StHigh;
                end
            end
            StHigh: begin
                if (w_tick) begin
                    w_hi_cnt_nxt   = w_hi_inc;
                    w_per_cnt_nxt  = w_per_inc;
                    w_idle_cnt_nxt = w_idle_inc;
                end
                if (w_fall) begin
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = StLow;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                    w_lost_nxt  = 1'b1;
                end
            end
            StLow: begin
                if (w_tick) begin
                    w_per_cnt_nxt  = w_per_inc;
                    w_idle_cnt_nxt = w_idle_inc;
                end
                if (w_rise) begin
                    w_pulse_width_nxt = r_hi_cnt;
                    // Include the tick landing on the rise edge itself.
                    w_period_nxt      = w_tick ? w_per_inc : r_per_cnt;
                    w_oor_nxt         = (r_hi_cnt < MinVal) || (r_hi_cnt > MaxVal);
                    w_valid_nxt       = 1'b1;
                    w_lost_nxt        = 1'b0;
                    w_hi_cnt_nxt      = '0;
                    w_per_cnt_nxt     = '0;
                    w_idle_cnt_nxt    = '0;
                    w_state_nxt       = StHigh;
                end else if (w_timeout) begin
                    w_state_nxt = StIdle;
                    w_lost_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= StIdle;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_prev        <= 1'b0;
            r_presc       <= '0;
            r_hi_cnt      <= '0;
            r_per_cnt     <= '0;
            r_idle_cnt    <= '0;
            r_pulse_width <= '0;
            r_period      <= '0;
            r_valid       <= 1'b0;
            r_oor         <= 1'b0;
            r_lost        <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_sync1       <= pwm_in;
            r_sync2       <= r_sync1;
            r_prev        <= r_sync2;
            r_presc       <= w_presc_nxt;
            r_hi_cnt      <= w_hi_cnt_nxt;
            r_per_cnt     <= w_per_cnt_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_pulse_width <= w_pulse_width_nxt;
            r_period      <= w_period_nxt;
            r_valid       <= w_valid_nxt;
            r_oor         <= w_oor_nxt;
            r_lost        <= w_lost_nxt;
        end
    end

    assign pulse_width  = r_pulse_width;
    assign period       = r_period;
    assign valid        = r_valid;
    assign out_of_range = r_oor;
    assign signal_lost  = r_lost;

endmodule
